// File: rtl/wb_line_prefetch.sv
// Wishbone classic read master that fetches a line of consecutive words into a
// show-ahead FIFO for a pixel consumer. One transaction is outstanding at a
// time; the fetch pauses when the FIFO fills and resumes as it drains.
module wb_line_prefetch #(
  parameter int WB_ADDR_WIDTH = 24,
  parameter int WB_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int LEN_WIDTH     = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [WB_ADDR_WIDTH-1:0]         base_adr_i,
  input  logic [LEN_WIDTH-1:0]             len_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             wb_cyc_o,
  output logic                             wb_stb_o,
  output logic                             wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0]         wb_adr_o,
  output logic [WB_DATA_WIDTH/8-1:0]       wb_sel_o,
  input  logic                             wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]         wb_dat_i,
  input  logic                             pix_rd_i,
  output logic [WB_DATA_WIDTH-1:0]         pix_data_o,
  output logic                             pix_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level_o,
  output logic                             underflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);

  logic [1:0]               state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0]     rem_q, rem_d;
  logic [LVL_W-1:0]         level_q, level_d, level_step_s;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic                     underflow_q, underflow_d;
  logic [WB_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push_s, pop_s, start_acc_s, empty_s;

  // Abort wins over everything, so an ack in the abort cycle never lands in the FIFO.
  assign empty_s     = (level_q == LVL_ZERO);
  assign push_s      = (state_q == S_REQ) && wb_ack_i && !abort_i;
  assign pop_s       = pix_rd_i && !empty_s && !abort_i;
  assign start_acc_s = (state_q == S_IDLE) && start_i && !abort_i;

  // Sticky underflow: set by any pop on an empty FIFO, cleared only by an accepted start.
  assign underflow_d = (pix_rd_i && empty_s) || (underflow_q && !start_acc_s);

  // Level after this cycle's push and pop; abort flushes to zero.
  always_comb begin
    level_step_s = level_q;
    if (push_s && !pop_s) begin
      level_step_s = level_q + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_step_s = level_q - LVL_W'(1);
    end else begin
      level_step_s = level_q;
    end
    if (abort_i) begin
      level_d = LVL_ZERO;
    end else begin
      level_d = level_step_s;
    end
  end

  // Fetch sequencer: address/remaining bookkeeping and pause on a full FIFO.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i == LEN_WIDTH'(0)) begin
              state_d = S_DONE;
            end else begin
              adr_d   = base_adr_i;
              rem_d   = len_i;
              state_d = (level_q == LVL_FULL) ? S_WAIT : S_REQ;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REQ: begin
          if (wb_ack_i) begin
            adr_d = adr_q + WB_ADDR_WIDTH'(1);
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = S_DONE;
            end else if (level_step_s == LVL_FULL) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (level_step_s < LVL_FULL) begin
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control and FIFO pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      rem_q       <= '0;
      level_q     <= LVL_ZERO;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      rem_q       <= rem_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
      if (abort_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_q <= pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      end
    end
  end

  // FIFO storage; contents are don't-care while the level is zero.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wb_dat_i;
    end
  end

  assign busy_o       = (state_q == S_REQ) || (state_q == S_WAIT);
  assign done_o       = (state_q == S_DONE);
  assign wb_cyc_o     = (state_q == S_REQ);
  assign wb_stb_o     = (state_q == S_REQ);
  assign wb_we_o      = 1'b0;
  assign wb_sel_o     = {(WB_DATA_WIDTH/8){1'b1}};
  assign wb_adr_o     = adr_q;
  assign pix_data_o   = mem_q[rd_ptr_q];
  assign pix_valid_o  = !empty_s;
  assign fifo_level_o = level_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_wb_line_prefetch.sv
// Randomized bench for wb_line_prefetch: a transaction-level model (word queue,
// next address, words remaining) predicts every output each cycle.
module tb_wb_line_prefetch;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [23:0] base_adr_i = 24'h0;
  logic [9:0]  len_i = 10'h0;
  logic        busy_o, done_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [23:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic [15:0] wb_dat_i = 16'h0;
  logic        pix_rd_i = 1'b0;
  logic [15:0] pix_data_o;
  logic        pix_valid_o;
  logic [4:0]  fifo_level_o;
  logic        underflow_o;

  wb_line_prefetch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .base_adr_i(base_adr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i), .pix_rd_i(pix_rd_i), .pix_data_o(pix_data_o),
    .pix_valid_o(pix_valid_o), .fifo_level_o(fifo_level_o),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = fetching, 2 = done pulse.
  int          m_phase = 0;
  int          m_rem   = 0;
  bit          m_wait  = 1'b0;
  bit          m_under = 1'b0;
  logic [23:0] m_adr   = 24'h0;
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_cyc();
    return (m_phase == 1) && !m_wait;
  endfunction

  task automatic check_outputs();
    chk("busy", {31'h0, busy_o}, {31'h0, m_phase == 1});
    chk("done", {31'h0, done_o}, {31'h0, m_phase == 2});
    chk("cyc", {31'h0, wb_cyc_o}, {31'h0, exp_cyc()});
    chk("stb", {31'h0, wb_stb_o}, {31'h0, exp_cyc()});
    chk("we", {31'h0, wb_we_o}, 32'h0);
    chk("sel", {30'h0, wb_sel_o}, 32'h3);
    chk("level", {27'h0, fifo_level_o}, q.size());
    chk("valid", {31'h0, pix_valid_o}, {31'h0, q.size() != 0});
    if (q.size() != 0) chk("pix_data", {16'h0, pix_data_o}, {16'h0, q[0]});
    if (exp_cyc()) chk("adr", {8'h0, wb_adr_o}, {8'h0, m_adr});
    chk("underflow", {31'h0, underflow_o}, {31'h0, m_under});
  endtask

  // One clock: check, drive, then apply the specification's rules to the model.
  task automatic step(input bit st, input logic [23:0] b, input logic [9:0] l,
                      input bit ab, input int pp, input int ackp);
    bit pop, ack, was_full;
    logic [15:0] dat;
    @(negedge clk_i);
    check_outputs();
    pop = ($urandom_range(99) < pp);
    ack = exp_cyc() ? ($urandom_range(99) < ackp) : ($urandom_range(99) < 5);
    dat = 16'($urandom);
    start_i = st; base_adr_i = b; len_i = l; abort_i = ab;
    pix_rd_i = pop; wb_ack_i = ack; wb_dat_i = dat;
    @(posedge clk_i);
    was_full = (q.size() == DEPTH);
    if (!ab && m_phase == 0 && st) m_under = 1'b0;
    if (pop && q.size() == 0) m_under = 1'b1;
    if (ab) begin
      q.delete();
      m_phase = 0;
      m_wait  = 1'b0;
    end else begin
      if (pop && q.size() != 0) void'(q.pop_front());
      case (m_phase)
        0: if (st) begin
             if (l == 10'd0) m_phase = 2;
             else begin
               m_phase = 1; m_rem = int'(l); m_adr = b; m_wait = was_full;
             end
           end
        1: if (m_wait) begin
             if (q.size() < DEPTH) m_wait = 1'b0;
           end else if (ack) begin
             q.push_back(dat);
             m_adr = m_adr + 24'd1;
             m_rem--;
             if (m_rem == 0) m_phase = 2;
             else if (q.size() == DEPTH) m_wait = 1'b1;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; abort_i = 1'b0; pix_rd_i = 1'b0; wb_ack_i = 1'b0;
  endtask

  task automatic run_to_idle(input int pp, input int ackp);
    int budget = 400;
    while (m_phase != 0 && budget > 0) begin
      step(1'b0, 24'h0, 10'h0, 1'b0, pp, ackp);
      budget--;
    end
    if (budget == 0) chk("timeout_idle", 32'h0, 32'h1);
  endtask

  task automatic drain();
    int budget = 100;
    while (q.size() != 0 && budget > 0) begin
      step(1'b0, 24'h0, 10'h0, 1'b0, 100, 0);
      budget--;
    end
    if (budget == 0) chk("timeout_drain", 32'h0, 32'h1);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 0);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_we", {31'h0, wb_we_o}, 32'h0);
    chk("rst_valid", {31'h0, pix_valid_o}, 32'h0);
    chk("rst_under", {31'h0, underflow_o}, 32'h0);
    chk("rst_adr", {8'h0, wb_adr_o}, 32'h0);
    chk("rst_level", {27'h0, fifo_level_o}, 32'h0);
    chk("rst_sel", {30'h0, wb_sel_o}, 32'h3);
  endtask

  initial begin
    int budget;
    #3 check_reset_values();
    @(negedge clk_i) rst_ni = 1'b1;

    // Short line, fast slave, idle consumer: four words land in order.
    step(1'b1, 24'h000100, 10'd4, 1'b0, 0, 100);
    run_to_idle(0, 100);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 0);
    chk("line4_level", {27'h0, fifo_level_o}, 32'd4);
    drain();

    // Longer than the FIFO: stall at 16, one pop buys exactly one more word.
    step(1'b1, 24'h000200, 10'd20, 1'b0, 0, 100);
    budget = 100;
    while (!m_wait && budget > 0) begin
      step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
      budget--;
    end
    if (budget == 0) chk("timeout_fill", 32'h0, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
    chk("stall_level", {27'h0, fifo_level_o}, 32'd16);
    step(1'b0, 24'h0, 10'h0, 1'b0, 100, 100);
    for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
    run_to_idle(60, 100);
    drain();

    // Address wrap at the top of the space.
    step(1'b1, 24'hFFFFFE, 10'd3, 1'b0, 0, 70);
    run_to_idle(0, 70);
    drain();

    // Zero length: done next cycle, no bus traffic.
    step(1'b1, 24'h000400, 10'd0, 1'b0, 0, 100);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);

    // Abort coinciding with an ack, then a normal fetch.
    step(1'b1, 24'h000500, 10'd8, 1'b0, 0, 100);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
    step(1'b1, 24'h000900, 10'd5, 1'b1, 0, 100);
    step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
    chk("abort_level", {27'h0, fifo_level_o}, 32'd0);
    step(1'b1, 24'h000600, 10'd3, 1'b0, 0, 100);
    run_to_idle(30, 100);
    drain();

    // Underflow is sticky until the next start.
    step(1'b0, 24'h0, 10'h0, 1'b0, 100, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 10'h0, 1'b0, 0, 0);
    step(1'b1, 24'h000700, 10'd2, 1'b0, 0, 100);
    run_to_idle(0, 100);
    drain();

    // Random traffic: starts (ignored when busy), pops, stray acks, rare aborts.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(9) == 0, 24'($urandom), 10'($urandom_range(40)),
           $urandom_range(60) == 0, $urandom_range(70), $urandom_range(20, 100));
    end
    run_to_idle(50, 80);
    drain();

    // Reset in the middle of a burst.
    step(1'b1, 24'h000800, 10'd12, 1'b0, 0, 100);
    budget = 50;
    while (!(exp_cyc() && q.size() >= 2) && budget > 0) begin
      step(1'b0, 24'h0, 10'h0, 1'b0, 0, 100);
      budget--;
    end
    if (budget == 0) chk("timeout_burst", 32'h0, 32'h1);
    @(negedge clk_i);
    idle_inputs();
    #2 rst_ni = 1'b0;
    #1 check_reset_values();
    @(negedge clk_i) rst_ni = 1'b1;
    q.delete(); m_phase = 0; m_wait = 1'b0; m_under = 1'b0; m_adr = 24'h0;
    step(1'b1, 24'h000A00, 10'd4, 1'b0, 20, 100);
    run_to_idle(20, 100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
